// File: rtl/can_frame_rx.sv
// can_frame_rx: raw bit-level receiver for one CAN standard data frame.
// Oversamples the bus, detects SOF on a falling edge, samples every bit at
// mid-bit and presents a fixed-length frame image (stuff bits still present)
// with a one-clock valid strobe.
// Optional build macro: CAN_RX_SYNC_EN adds a 2-flop synchronizer on
// i_Rx_Serial ahead of the rx register (+2 clocks latency, same sample points).
module can_frame_rx #(
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter int unsigned FRAME_BITS   = 108
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Rx_Serial,
    output logic                  o_Rx_DV,
    output logic [0:FRAME_BITS-1] o_Rx_Byte
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(FRAME_BITS + 1);
    localparam int unsigned HALF  = (CLKS_PER_BIT - 1) / 2;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START_CHK,
        DATA,
        DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        clk_cnt, clk_cnt_nxt;
    logic [IDX_W-1:0]        bit_idx, bit_idx_nxt;
    logic [0:FRAME_BITS-1]   shift, shift_nxt;
    logic                    dv_nxt;
    logic [0:FRAME_BITS-1]   byte_nxt;

    logic rx_in;
    logic rx;
    logic prev;

`ifdef CAN_RX_SYNC_EN
    logic [1:0] sync;

    // Metastability synchronizer; left unreset so a held dominant bus never looks like an edge.
    always_ff @(posedge i_Clock) begin
        sync <= {sync[0], i_Rx_Serial};
    end

    assign rx_in = sync[1];
`else
    assign rx_in = i_Rx_Serial;
`endif

    // Input register and one-clock delayed copy for falling-edge detection (no reset on purpose).
    always_ff @(posedge i_Clock) begin
        rx   <= rx_in;
        prev <= rx;
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            o_Rx_DV   <= 1'b0;
            o_Rx_Byte <= '0;
        end else begin
            state     <= state_nxt;
            clk_cnt   <= clk_cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shift     <= shift_nxt;
            o_Rx_DV   <= dv_nxt;
            o_Rx_Byte <= byte_nxt;
        end
    end

    // Next-state logic; the strobe and frame image are loaded on entry to DONE
    // so o_Rx_DV is high exactly while the FSM sits in DONE.
    always_comb begin
        state_nxt   = state;
        clk_cnt_nxt = clk_cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        dv_nxt      = 1'b0;
        byte_nxt    = o_Rx_Byte;

        unique case (state)
            IDLE: begin
                clk_cnt_nxt = '0;
                bit_idx_nxt = '0;
                if (prev && !rx) begin
                    state_nxt = START_CHK;
                end
            end

            START_CHK: begin
                if (clk_cnt == CNT_HALF) begin
                    clk_cnt_nxt = '0;
                    if (!rx) begin
                        shift_nxt[0] = 1'b0;
                        bit_idx_nxt  = IDX_ONE;
                        state_nxt    = DATA;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + CNT_W'(1);
                end
            end

            DATA: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_nxt        = '0;
                    shift_nxt[bit_idx] = rx;
                    if (bit_idx == IDX_LAST) begin
                        bit_idx_nxt = '0;
                        dv_nxt      = 1'b1;
                        byte_nxt    = shift_nxt;
                        state_nxt   = DONE;
                    end else begin
                        bit_idx_nxt = bit_idx + IDX_W'(1);
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + CNT_W'(1);
                end
            end

            DONE: begin
                clk_cnt_nxt = '0;
                bit_idx_nxt = '0;
                state_nxt   = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_can_frame_rx.sv
// tb_can_frame_rx: randomized self-checking bench for can_frame_rx.
// Reference model: every frame sent is queued with its SOF clock; each
// o_Rx_DV pulse must deliver the next queued frame within the nominal latency.
module tb_can_frame_rx;

    localparam int unsigned CPB = 10;
    localparam int unsigned FB  = 108;
`ifdef CAN_RX_SYNC_EN
    localparam int LAT_NOM = 1078;
`else
    localparam int LAT_NOM = 1076;
`endif

    logic          i_Clock = 1'b0;
    logic          i_Reset = 1'b1;
    logic          i_Rx_Serial = 1'b0;
    logic          o_Rx_DV;
    logic [0:FB-1] o_Rx_Byte;

    can_frame_rx #(
        .CLKS_PER_BIT(CPB),
        .FRAME_BITS  (FB)
    ) dut (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .i_Rx_Serial(i_Rx_Serial),
        .o_Rx_DV    (o_Rx_DV),
        .o_Rx_Byte  (o_Rx_Byte)
    );

    always #50 i_Clock = ~i_Clock;

    int cyc = 0;
    always @(posedge i_Clock) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic [0:FB-1] got_q[$];
    int            got_cyc[$];
    logic [0:FB-1] exp_q[$];
    int            exp_sof[$];

    logic [0:FB-1] spec_frame = 108'b0101101010111110110011011010101110100000001001011001010011011100_00001000000001010101010101001100000001110011;
    logic [0:FB-1] last_frame;

    // Capture every strobe with the clock it was seen on.
    always @(negedge i_Clock) begin
        if (o_Rx_DV === 1'b1) begin
            got_q.push_back(o_Rx_Byte);
            got_cyc.push_back(cyc);
        end
    end

    task automatic check_val(input string tag, input logic [FB-1:0] got, input logic [FB-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge i_Clock);
            i_Rx_Serial = 1'b1;
        end
    endtask

    task automatic glitch(input int len);
        repeat (len) begin
            @(negedge i_Clock);
            i_Rx_Serial = 1'b0;
        end
        @(negedge i_Clock);
        i_Rx_Serial = 1'b1;
    endtask

    function automatic logic [0:FB-1] rand_frame();
        logic [0:FB-1] f;
        for (int i = 0; i < int'(FB); i++) f[i] = 1'($urandom_range(0, 1));
        f[0] = 1'b0;
        return f;
    endfunction

    // Drive one frame bit by bit; rst_bit >= 0 pulses reset for one clock at that bit.
    task automatic send_frame(input logic [0:FB-1] f, input int rst_bit, input bit expect_it);
        for (int i = 0; i < int'(FB); i++) begin
            for (int j = 0; j < int'(CPB); j++) begin
                @(negedge i_Clock);
                if (j == 0) i_Rx_Serial = f[i];
                if (i == 0 && j == 0 && expect_it) begin
                    exp_q.push_back(f);
                    exp_sof.push_back(cyc);
                end
                i_Reset = (i == rst_bit && j == 0);
            end
        end
        @(negedge i_Clock);
        i_Rx_Serial = 1'b1;
        i_Reset     = 1'b0;
    endtask

    // Wait (bounded) for all expected frames, then compare count, data and latency.
    task automatic drain(input string tag);
        for (int k = 0; k < 1300 && got_q.size() < exp_q.size(); k++) idle(1);
        idle(3);
        check_val({tag, "_count"}, FB'(got_q.size()), FB'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            int lat;
            lat = got_cyc[i] - exp_sof[i];
            check_val({tag, "_data"}, got_q[i], exp_q[i]);
            check_val({tag, "_latency_in_window"}, FB'(lat >= LAT_NOM - 2 && lat <= LAT_NOM + 2), FB'(1));
            last_frame = exp_q[i];
        end
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
        exp_sof.delete();
    endtask

    initial begin
        logic [0:FB-1] f;

        // Reset with the bus already dominant.
        repeat (5) @(negedge i_Clock);
        check_val("reset_dv", FB'(o_Rx_DV), FB'(0));
        check_val("reset_byte", o_Rx_Byte, '0);
        i_Reset = 1'b0;

        // Bus held dominant from reset release: no edge, no frame.
        repeat (300) @(negedge i_Clock);
        check_val("held_low_count", FB'(got_q.size()), FB'(0));
        check_val("held_low_byte", o_Rx_Byte, '0);
        idle(30);
        check_val("held_low_rise_count", FB'(got_q.size()), FB'(0));

        // Short dominant glitches on the idle bus must be rejected.
        glitch(3);
        idle(150);
        check_val("glitch3_count", FB'(got_q.size()), FB'(0));
        check_val("glitch3_byte", o_Rx_Byte, '0);
        for (int g = 0; g < 4; g++) begin
            glitch(int'($urandom_range(1, 3)));
            idle(int'($urandom_range(20, 60)));
        end
        check_val("glitch_rand_count", FB'(got_q.size()), FB'(0));
        check_val("glitch_rand_byte", o_Rx_Byte, '0);

        // Reference frame.
        send_frame(spec_frame, -1, 1'b1);
        drain("spec_frame");

        // Two identical frames with one bit of idle between them.
        f = rand_frame();
        idle(20);
        send_frame(f, -1, 1'b1);
        idle(CPB - 1);
        send_frame(f, -1, 1'b1);
        drain("back_to_back");

        // Random frames with random idle gaps.
        for (int n = 0; n < 5; n++) begin
            idle(int'($urandom_range(0, 24)));
            send_frame(rand_frame(), -1, 1'b1);
        end
        drain("random");

        // Glitch after frames leaves the captured frame untouched.
        glitch(3);
        idle(150);
        check_val("glitch_hold_count", FB'(got_q.size()), FB'(0));
        check_val("glitch_hold_byte", o_Rx_Byte, last_frame);

        // Reset pulse mid-frame, just after bit 40.
        idle(20);
        send_frame(rand_frame(), 41, 1'b0);
        check_val("midreset_count", FB'(got_q.size()), FB'(0));
        check_val("midreset_dv", FB'(o_Rx_DV), FB'(0));
        check_val("midreset_byte", o_Rx_Byte, '0);

        // Let any capture started by the frame tail run out, then receive cleanly.
        idle(1300);
        got_q.delete();
        got_cyc.delete();
        send_frame(spec_frame, -1, 1'b1);
        drain("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
